// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with write bypass and clear sequencer.
// Define REG_FILE_SCOREBOARD_EN to add the pending-write busy scoreboard.
module reg_file_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr_i,
   output logic                          ready_o,
   input  logic [NRD*$clog2(NREG)-1:0]   raddr_i,
   output logic [NRD*XLEN-1:0]           rdata_o,
   input  logic                          we_i,
   input  logic [$clog2(NREG)-1:0]       waddr_i,
   input  logic [XLEN-1:0]               wdata_i,
   input  logic                          issue_en_i,
   input  logic [$clog2(NREG)-1:0]       issue_addr_i,
   output logic [NRD-1:0]                rd_busy_o
);

   localparam int AW = $clog2(NREG);
   localparam logic [AW-1:0] LAST = AW'(NREG - 1);
   localparam logic [AW-1:0] FIRST = AW'(1);

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   state_e                  state_q;
   logic [AW-1:0]           clr_cnt_q;
   logic                    ready_q;
   logic [XLEN-1:0]         mem_q [NREG];
   logic                    wr_ok;
   logic [AW-1:0]           ra;
   logic                    byp;

   assign ready_o = ready_q;
   assign wr_ok   = we_i && ready_q && (waddr_i != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_cnt_q <= FIRST;
         ready_q   <= 1'b0;
      end else begin
         unique case (state_q)
            CLEAR: begin
               if (clr_cnt_q == LAST) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + FIRST;
               end
            end
            IDLE: begin
               if (clr_i) begin
                  state_q   <= CLEAR;
                  clr_cnt_q <= FIRST;
                  ready_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= CLEAR;
            end
         endcase
      end
   end

   // The array itself is not reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (!ready_q) begin
         mem_q[clr_cnt_q] <= '0;
      end else if (wr_ok) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

`ifdef REG_FILE_SCOREBOARD_EN
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Set follows clear so a new producer wins over a retiring one.
   always_comb begin
      busy_d = busy_q;
      if (ready_q) begin
         if (we_i) begin
            busy_d[waddr_i] = 1'b0;
         end
         if (issue_en_i && (issue_addr_i != '0)) begin
            busy_d[issue_addr_i] = 1'b1;
         end
         if (clr_i) begin
            busy_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end
`else
   logic unused_sb;
   assign unused_sb = ^{issue_en_i, issue_addr_i};
`endif

   always_comb begin
      rdata_o   = '0;
      rd_busy_o = '0;
      ra        = '0;
      byp       = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         ra  = raddr_i[k*AW +: AW];
         byp = we_i && ready_q && (waddr_i == ra);
         if (ready_q && (ra != '0)) begin
            if (byp) begin
               rdata_o[k*XLEN +: XLEN] = wdata_i;
            end else begin
               rdata_o[k*XLEN +: XLEN] = mem_q[ra];
            end
`ifdef REG_FILE_SCOREBOARD_EN
            rd_busy_o[k] = busy_q[ra] && !byp;
`endif
         end
      end
   end

endmodule
